issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Single-issue grant scheduler between the reservation stations and the four
//  functional units: int ALU, multiplier_wrapper, divider_wrapper, load buffer.
//  Picks at most one ready unit per cycle.
//  Reserves the common data bus (CDB) slot in which that unit's result returns,
//  so no two units ever drive the CDB in the same cycle.
//  Drives the CDB source select for the CDB mux.
// PARAMETERS
//  MULT_LAT  4  cycles from issue_mult to multiplier result on CDB (pipelined)
//  DIV_LAT   6  cycles from issue_div to divider result on CDB; must be >= all other LATs
//  LD_LAT    2  cycles from issue_ld_buf to load result on CDB
//  Int latency is fixed at 1.
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  synchronous, active-low (0 = reset)
//  ready_int     in   1  int RS has an instruction ready
//  ready_mult    in   1  mult RS has an instruction ready
//  ready_div     in   1  div RS has an instruction ready
//  ready_ld_buf  in   1  load buffer has an entry ready
//  div_busy      in   1  divider_wrapper busy (non-pipelined unit)
//  issue_int     out  1  grant to int; unit captures operands this edge
//  issue_mult    out  1  grant to multiplier
//  issue_div     out  1  grant to divider
//  issue_ld_buf  out  1  grant to load buffer
//  cdb_valid     out  1  a unit owns the CDB this cycle
//  cdb_sel       out  2  CDB owner: 0 int, 1 mult, 2 div, 3 ld_buf
// BEHAVIOUR
//  Slot table:
//  - S[0..DIV_LAT] of {valid, owner[1:0]}; S[k] = CDB owner k cycles from now.
//  - S[0] drives cdb_valid/cdb_sel directly (registered).
//  Eligibility: unit x eligible iff ready_x && !S[LAT_x].valid.
//  - div is additionally eligible only if !div_busy.
//  Grant:
//  - issue_* is combinational from ready_*, div_busy and the registered S.
//  - At most one issue_* high per cycle (one-hot or zero).
//  - Fixed priority: div > mult > ld_buf > int (longest latency first).
//  Handshake:
//  - Grant completes in the cycle issue_x is high.
//  - A stalled requester keeps ready_x high. Dropping ready_x without a grant is legal: no effect.
//  Update at each edge:
//  - S'[k] = S[k+1] for k < DIV_LAT; S'[DIV_LAT] = 0.
//  - If x is granted, S'[LAT_x-1] = {1, id_x}.
//  - The new entry never collides with an existing one (eligibility guarantees this).
//  Timing: grant in cycle t => cdb_valid=1, cdb_sel=id_x in cycle t+LAT_x.
//  - Int: result in cycle t+1.
//  Back-to-back: mult may issue every cycle. Div is throttled only by div_busy.
//  Reset (reset=0):
//  - All issue_* forced 0 the same cycle.
//  - All S entries cleared at the edge, so cdb_valid=0, cdb_sel=0 the next cycle.
//  - Mid-operation reset drops all reservations. Units are reset together; no stale CDB drive.
//  Reset values: issue_*=0, cdb_valid=0, cdb_sel=2'd0.
// CONFIGURATION
//  ISSUE_RR_EN defined:
//  - Rotating priority over {int, mult, div, ld_buf}.
//  - 2-bit pointer; after a grant to id g it points to g+1 mod 4.
//  - The first eligible unit at or after the pointer wins. Pointer resets to 0 (int).
//  - No grant leaves the pointer unchanged.
//  ISSUE_RR_EN undefined: fixed priority as above; no pointer register.
//  Slot table and eligibility are identical in both builds.
// TESTING
//  1. reset=0 with all ready=1 -> all issue_*=0. Next cycle cdb_valid=0. After release, issue_div=1 first (fixed).
//  2. ready_int=1 for one cycle at t -> issue_int=1 at t; cdb_valid=1, cdb_sel=0 at t+1.
//  3. issue_mult at t; ready_int at t+3 -> issue_int=0 at t+3 (slot t+4 held), issue_int=1 at t+4.
//     CDB: sel=1 at t+4, sel=0 at t+5.
//  4. ready_div=1 with div_busy=1 for 3 cycles -> no grant. div_busy->0 at t -> issue_div=1 at t; cdb_sel=2 at t+6.
//  5. All four ready from t, each dropped once granted -> div@t, mult@t+1, ld@t+2, int@t+6.
//     CDB owners: ld t+4, mult t+5, div t+6, int t+7.
//  6. LD_LAT=1; int and ld_buf held ready 8 cycles -> fixed: issue_ld_buf every cycle, int starved.
//     ISSUE_RR_EN: grants alternate int, ld_buf, int, ...; cdb_valid=1 every cycle from t+1.

Source files
------------

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Single-issue grant scheduler between the reservation stations and the four
// functional units (int ALU, multiplier, divider, load buffer). At most one
// unit is granted per cycle. The grant also reserves the common data bus (CDB)
// slot in which that unit's result returns, so no two units ever drive the
// CDB in the same cycle. The head of the reservation table drives the CDB
// source select directly from a register.
//
// Build option:
//   ISSUE_RR_EN  defined   -> rotating priority over {int, mult, div, ld_buf}
//                             driven by a 2-bit pointer.
//                undefined -> fixed priority div > mult > ld_buf > int.
//   The slot table and the eligibility rules are the same in both builds.
//
// Parameters:
//   MULT_LAT  issue_mult to multiplier result on the CDB (pipelined unit)
//   DIV_LAT   issue_div to divider result on the CDB; the longest latency
//   LD_LAT    issue_ld_buf to load result on the CDB
//   The int ALU latency is fixed at 1.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-low (0 = reset)
//   ready_int     in   int RS has an instruction ready
//   ready_mult    in   mult RS has an instruction ready
//   ready_div     in   div RS has an instruction ready
//   ready_ld_buf  in   load buffer has an entry ready
//   div_busy      in   divider busy (non-pipelined unit)
//   issue_int     out  grant to int ALU (combinational)
//   issue_mult    out  grant to multiplier (combinational)
//   issue_div     out  grant to divider (combinational)
//   issue_ld_buf  out  grant to load buffer (combinational)
//   cdb_valid     out  a unit owns the CDB this cycle (registered)
//   cdb_sel       out  CDB owner: 0 int, 1 mult, 2 div, 3 ld_buf (registered)
// -----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 6,
  parameter int LD_LAT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_int,
  input  logic       ready_mult,
  input  logic       ready_div,
  input  logic       ready_ld_buf,
  input  logic       div_busy,
  output logic       issue_int,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       issue_ld_buf,
  output logic       cdb_valid,
  output logic [1:0] cdb_sel
);

  localparam int INT_LAT = 1;

  // Unit identifiers; also the bit position of each unit in the grant vectors.
  localparam logic [1:0] ID_INT  = 2'd0;
  localparam logic [1:0] ID_MULT = 2'd1;
  localparam logic [1:0] ID_DIV  = 2'd2;
  localparam logic [1:0] ID_LD   = 2'd3;

  // Slot table: entry k describes the CDB owner k cycles from now.
  logic [DIV_LAT:0]       slot_valid_r;
  logic [DIV_LAT:0][1:0]  slot_owner_r;
  logic [DIV_LAT:0]       slot_valid_nxt_s;
  logic [DIV_LAT:0][1:0]  slot_owner_nxt_s;

  // Per-unit eligibility and one-hot grant, indexed by unit id.
  logic [3:0] elig_vec_s;
  logic [3:0] grant_vec_s;
  logic       grant_any_s;
  logic [1:0] grant_id_s;

  // A unit may issue only if the slot its result will land in is still free
  // (entry LAT now becomes entry LAT-1 after this edge's shift). Eligibility
  // is masked by reset so that no grant escapes while the block is in reset.
  assign elig_vec_s[ID_INT]  = reset & ready_int    & ~slot_valid_r[INT_LAT];
  assign elig_vec_s[ID_MULT] = reset & ready_mult   & ~slot_valid_r[MULT_LAT];
  assign elig_vec_s[ID_DIV]  = reset & ready_div    & ~slot_valid_r[DIV_LAT] & ~div_busy;
  assign elig_vec_s[ID_LD]   = reset & ready_ld_buf & ~slot_valid_r[LD_LAT];

`ifdef ISSUE_RR_EN
  // Rotating priority: the first eligible unit at or after the pointer wins.
  logic [1:0] rr_ptr_r;
  logic [1:0] rr_cand_s;
  logic       rr_found_s;

  // Round-robin arbiter over the four eligibility bits.
  always_comb begin
    grant_vec_s = 4'b0000;
    rr_found_s  = 1'b0;
    rr_cand_s   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rr_cand_s = rr_ptr_r + 2'(i);
      if (!rr_found_s && elig_vec_s[rr_cand_s]) begin
        grant_vec_s[rr_cand_s] = 1'b1;
        rr_found_s             = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Pointer moves just past the granted unit; an idle cycle leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r <= 2'd0;
    end else if (grant_any_s) begin
      rr_ptr_r <= grant_id_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority, longest latency first: div > mult > ld_buf > int.
  always_comb begin
    grant_vec_s = 4'b0000;
    if (elig_vec_s[ID_DIV]) begin
      grant_vec_s[ID_DIV] = 1'b1;
    end else if (elig_vec_s[ID_MULT]) begin
      grant_vec_s[ID_MULT] = 1'b1;
    end else if (elig_vec_s[ID_LD]) begin
      grant_vec_s[ID_LD] = 1'b1;
    end else if (elig_vec_s[ID_INT]) begin
      grant_vec_s[ID_INT] = 1'b1;
    end else begin
      grant_vec_s = 4'b0000;
    end
  end
`endif

  // Encode the one-hot grant into a unit id.
  always_comb begin
    grant_any_s = |grant_vec_s;
    case (grant_vec_s)
      4'b0001: grant_id_s = ID_INT;
      4'b0010: grant_id_s = ID_MULT;
      4'b0100: grant_id_s = ID_DIV;
      4'b1000: grant_id_s = ID_LD;
      default: grant_id_s = 2'd0;
    endcase
  end

  // Next slot table: shift toward the head, then book the granted unit's slot.
  always_comb begin
    slot_valid_nxt_s = {1'b0, slot_valid_r[DIV_LAT:1]};
    slot_owner_nxt_s = {2'b00, slot_owner_r[DIV_LAT:1]};
    case (grant_vec_s)
      4'b0001: begin
        slot_valid_nxt_s[INT_LAT-1] = 1'b1;
        slot_owner_nxt_s[INT_LAT-1] = ID_INT;
      end
      4'b0010: begin
        slot_valid_nxt_s[MULT_LAT-1] = 1'b1;
        slot_owner_nxt_s[MULT_LAT-1] = ID_MULT;
      end
      4'b0100: begin
        slot_valid_nxt_s[DIV_LAT-1] = 1'b1;
        slot_owner_nxt_s[DIV_LAT-1] = ID_DIV;
      end
      4'b1000: begin
        slot_valid_nxt_s[LD_LAT-1] = 1'b1;
        slot_owner_nxt_s[LD_LAT-1] = ID_LD;
      end
      default: begin
        slot_valid_nxt_s = slot_valid_nxt_s;
      end
    endcase
  end

  // Slot table register; reset drops every outstanding reservation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid_r <= '0;
      slot_owner_r <= '0;
    end else begin
      slot_valid_r <= slot_valid_nxt_s;
      slot_owner_r <= slot_owner_nxt_s;
    end
  end

  assign issue_int    = grant_vec_s[ID_INT];
  assign issue_mult   = grant_vec_s[ID_MULT];
  assign issue_div    = grant_vec_s[ID_DIV];
  assign issue_ld_buf = grant_vec_s[ID_LD];

  // Head of the table is the current CDB owner; owner bits are zero when idle.
  assign cdb_valid = slot_valid_r[0];
  assign cdb_sel   = slot_owner_r[0];

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler. u_dut uses default latencies;
// u_dut_ld1 uses LD_LAT=1 for the int/ld_buf contention case.
module tb_issue_scheduler;

  logic       clk;
  logic       reset;
  logic       ready_int, ready_mult, ready_div, ready_ld_buf, div_busy;
  logic       issue_int, issue_mult, issue_div, issue_ld_buf;
  logic       cdb_valid;
  logic [1:0] cdb_sel;

  logic       r2_int, r2_ld;
  logic       zero_s;
  logic       i2_int, i2_mult, i2_div, i2_ld;
  logic       c2_valid;
  logic [1:0] c2_sel;

  int n_total;
  int n_bad;

  // Grant vector encoding: bit 0 int, 1 mult, 2 div, 3 ld_buf.
  localparam logic [3:0] G_NONE = 4'b0000;
  localparam logic [3:0] G_INT  = 4'b0001;
  localparam logic [3:0] G_MULT = 4'b0010;
  localparam logic [3:0] G_DIV  = 4'b0100;
  localparam logic [3:0] G_LD   = 4'b1000;
  // CDB encoding {valid, sel}.
  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_INT  = 4'b0100;
  localparam logic [3:0] C_MULT = 4'b0101;
  localparam logic [3:0] C_DIV  = 4'b0110;
  localparam logic [3:0] C_LD   = 4'b0111;

  issue_scheduler u_dut (
    .clk          (clk),
    .reset        (reset),
    .ready_int    (ready_int),
    .ready_mult   (ready_mult),
    .ready_div    (ready_div),
    .ready_ld_buf (ready_ld_buf),
    .div_busy     (div_busy),
    .issue_int    (issue_int),
    .issue_mult   (issue_mult),
    .issue_div    (issue_div),
    .issue_ld_buf (issue_ld_buf),
    .cdb_valid    (cdb_valid),
    .cdb_sel      (cdb_sel)
  );

  issue_scheduler #(.LD_LAT(1)) u_dut_ld1 (
    .clk          (clk),
    .reset        (reset),
    .ready_int    (r2_int),
    .ready_mult   (zero_s),
    .ready_div    (zero_s),
    .ready_ld_buf (r2_ld),
    .div_busy     (zero_s),
    .issue_int    (i2_int),
    .issue_mult   (i2_mult),
    .issue_div    (i2_div),
    .issue_ld_buf (i2_ld),
    .cdb_valid    (c2_valid),
    .cdb_sel      (c2_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on u_dut: advance past the edge, drive inputs, check outputs.
  // rdy bits: 0 int, 1 mult, 2 div, 3 ld_buf.
  task automatic step(input logic rst, input logic [3:0] rdy, input logic busy,
                      input logic [3:0] exp_iss, input logic [3:0] exp_cdb,
                      input string tag);
    @(posedge clk);
    #1;
    reset        = rst;
    ready_int    = rdy[0];
    ready_mult   = rdy[1];
    ready_div    = rdy[2];
    ready_ld_buf = rdy[3];
    div_busy     = busy;
    #1;
    check({tag, "_iss"}, {issue_ld_buf, issue_div, issue_mult, issue_int}, exp_iss);
    check({tag, "_cdb"}, {1'b0, cdb_valid, cdb_sel}, exp_cdb);
  endtask

  // One cycle on u_dut_ld1.
  task automatic step2(input logic ri, input logic rl,
                       input logic [3:0] exp_iss, input logic [3:0] exp_cdb,
                       input string tag);
    @(posedge clk);
    #1;
    r2_int = ri;
    r2_ld  = rl;
    #1;
    check({tag, "_iss"}, {i2_ld, i2_div, i2_mult, i2_int}, exp_iss);
    check({tag, "_cdb"}, {1'b0, c2_valid, c2_sel}, exp_cdb);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    zero_s  = 1'b0;
    r2_int  = 1'b0;
    r2_ld   = 1'b0;
    reset   = 1'b0;
    ready_int = 1'b1; ready_mult = 1'b1; ready_div = 1'b1; ready_ld_buf = 1'b1;
    div_busy  = 1'b0;

    // Reset with everything ready: no grants, CDB idle.
    step(1'b0, 4'hF, 1'b0, G_NONE, C_NONE, "rst0");
    step(1'b0, 4'hF, 1'b0, G_NONE, C_NONE, "rst1");

    // Release with all four ready, each dropped once granted.
`ifdef ISSUE_RR_EN
    step(1'b1, 4'b1111, 1'b0, G_INT,  C_NONE, "all_t0");
    step(1'b1, 4'b1110, 1'b0, G_MULT, C_INT,  "all_t1");
    step(1'b1, 4'b1100, 1'b0, G_DIV,  C_NONE, "all_t2");
    step(1'b1, 4'b1000, 1'b0, G_NONE, C_NONE, "all_t3");
    step(1'b1, 4'b1000, 1'b0, G_LD,   C_NONE, "all_t4");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_MULT, "all_t5");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_LD,   "all_t6");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "all_t7");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_DIV,  "all_t8");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "all_t9");
`else
    step(1'b1, 4'b1111, 1'b0, G_DIV,  C_NONE, "all_t0");
    step(1'b1, 4'b1011, 1'b0, G_MULT, C_NONE, "all_t1");
    step(1'b1, 4'b1001, 1'b0, G_LD,   C_NONE, "all_t2");
    step(1'b1, 4'b0001, 1'b0, G_NONE, C_NONE, "all_t3");
    step(1'b1, 4'b0001, 1'b0, G_NONE, C_LD,   "all_t4");
    step(1'b1, 4'b0001, 1'b0, G_NONE, C_MULT, "all_t5");
    step(1'b1, 4'b0001, 1'b0, G_INT,  C_DIV,  "all_t6");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_INT,  "all_t7");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "all_t8");
`endif

    // Single int request: result one cycle later.
    step(1'b1, 4'b0001, 1'b0, G_INT,  C_NONE, "int_t0");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_INT,  "int_t1");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "int_t2");

    // Int blocked by the slot a multiply already holds.
    step(1'b1, 4'b0010, 1'b0, G_MULT, C_NONE, "mi_t0");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mi_t1");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mi_t2");
    step(1'b1, 4'b0001, 1'b0, G_NONE, C_NONE, "mi_t3");
    step(1'b1, 4'b0001, 1'b0, G_INT,  C_MULT, "mi_t4");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_INT,  "mi_t5");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mi_t6");

    // Divider held off by div_busy, then issued.
    step(1'b1, 4'b0100, 1'b1, G_NONE, C_NONE, "busy0");
    step(1'b1, 4'b0100, 1'b1, G_NONE, C_NONE, "busy1");
    step(1'b1, 4'b0100, 1'b1, G_NONE, C_NONE, "busy2");
    step(1'b1, 4'b0100, 1'b0, G_DIV,  C_NONE, "div_t0");
    for (int k = 1; k < 6; k++) begin
      step(1'b1, 4'b0000, 1'b1, G_NONE, C_NONE, $sformatf("div_t%0d", k));
    end
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_DIV,  "div_t6");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "div_t7");

    // Mid-operation reset drops a pending multiply reservation.
    step(1'b1, 4'b0010, 1'b0, G_MULT, C_NONE, "mrst_t0");
    step(1'b0, 4'b1111, 1'b0, G_NONE, C_NONE, "mrst_t1");
    step(1'b0, 4'b0000, 1'b0, G_NONE, C_NONE, "mrst_t2");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mrst_t3");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mrst_t4");
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "mrst_t5");

    // Back-to-back multiplies, one per cycle.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b0010, 1'b0, G_MULT, C_NONE, $sformatf("b2b_i%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b0000, 1'b0, G_NONE, C_MULT, $sformatf("b2b_c%0d", k));
    end
    step(1'b1, 4'b0000, 1'b0, G_NONE, C_NONE, "b2b_end");

    // LD_LAT=1 instance: int and ld_buf held ready for 8 cycles.
    for (int k = 0; k < 8; k++) begin
`ifdef ISSUE_RR_EN
      step2(1'b1, 1'b1, (k % 2 == 0) ? G_INT : G_LD,
            (k == 0) ? C_NONE : ((k % 2 == 1) ? C_INT : C_LD),
            $sformatf("ld1_t%0d", k));
`else
      step2(1'b1, 1'b1, G_LD, (k == 0) ? C_NONE : C_LD, $sformatf("ld1_t%0d", k));
`endif
    end
`ifdef ISSUE_RR_EN
    step2(1'b0, 1'b0, G_NONE, C_LD,   "ld1_t8");
`else
    step2(1'b0, 1'b0, G_NONE, C_LD,   "ld1_t8");
`endif
    step2(1'b0, 1'b0, G_NONE, C_NONE, "ld1_t9");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
